// File: rtl/bn_res_pkg.sv
// Shared width helpers and fixed-point rounding/saturation functions for the BN-residual stage.
package bn_res_pkg;

    localparam int WIDE = 64;
    typedef logic signed [WIDE-1:0] wide_t;

    function automatic int pw_width(input int para_w, input int in_w);
        return para_w + in_w;
    endfunction

    function automatic int acc_width(input int pw, input int dw);
        return ((pw > dw) ? pw : dw) + 2;
    endfunction

    // Round half up, then arithmetic shift right by sh.
    function automatic wide_t rnd_shift(input wide_t acc, input int sh);
        wide_t r;
        if (sh > 0) begin
            r = (acc + (64'sd1 <<< (sh - 1))) >>> sh;
        end else begin
            r = acc;
        end
        return r;
    endfunction

    function automatic wide_t sat_clip(input wide_t acc, input int width);
        wide_t hi;
        wide_t lo;
        wide_t r;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (acc > hi) begin
            r = hi;
        end else if (acc < lo) begin
            r = lo;
        end else begin
            r = acc;
        end
        return r;
    endfunction

endpackage

// File: rtl/bn_res_lane.sv
// One channel: product register, add/round/saturate datapath and the registered result.
module bn_res_lane
    import bn_res_pkg::*;
#(
    parameter int IN_WIDTH   = 8,
    parameter int PARA_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_SHIFT = 0
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  s1_load,
    input  logic                  s2_load,
    input  logic [PARA_WIDTH-1:0] bn_a,
    input  logic [PARA_WIDTH-1:0] bn_b,
    input  logic [IN_WIDTH-1:0]   data_in,
    input  logic [DATA_WIDTH-1:0] res,
    input  logic                  res_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  sat
);

    localparam int PW  = pw_width(PARA_WIDTH, IN_WIDTH);
    localparam int ACC = acc_width(PW, DATA_WIDTH);

    logic signed [PW-1:0]         a_ext_s;
    logic signed [PW-1:0]         d_ext_s;
    logic signed [PW-1:0]         prod_r;
    logic signed [PARA_WIDTH-1:0] bn_b_r;
    logic signed [DATA_WIDTH-1:0] res_r;
    logic signed [ACC-1:0]        sum_s;
    wide_t                        rnd_s;
    wide_t                        clip_s;

    assign a_ext_s = PW'($signed(bn_a));
    assign d_ext_s = PW'($signed(data_in));

    // Stage-2 arithmetic on the captured stage-1 operands.
    always_comb begin
        sum_s = ACC'(prod_r) + ACC'(bn_b_r);
        if (res_en) begin
            sum_s = sum_s + ACC'(res_r);
        end else begin
            sum_s = sum_s;
        end
        rnd_s  = rnd_shift(wide_t'(sum_s), FRAC_SHIFT);
        clip_s = sat_clip(rnd_s, DATA_WIDTH);
        sat    = (clip_s != rnd_s);
    end

    // Stage-1 operand capture and stage-2 result register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            prod_r   <= '0;
            bn_b_r   <= '0;
            res_r    <= '0;
            data_out <= '0;
        end else begin
            if (s1_load) begin
                prod_r <= a_ext_s * d_ext_s;
                bn_b_r <= $signed(bn_b);
                res_r  <= $signed(res);
            end
            if (s2_load) begin
                data_out <= clip_s[DATA_WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/bn_res_pipe.sv
// Two-stage batch-norm scale/shift plus residual add with valid/ready flow control
// and a sticky count of beats that saturated.
module bn_res_pipe
    import bn_res_pkg::*;
#(
    parameter int IN_WIDTH    = 8,
    parameter int PARA_WIDTH  = 16,
    parameter int DATA_WIDTH  = 16,
    parameter int CHANNEL_NUM = 128,
    parameter int FM_DEPTH    = 64,
    parameter int FRAC_SHIFT  = 0,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                                   clk,
    input  logic                                   rstn,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic                                   res_en,
    input  logic [CHANNEL_NUM-1:0][PARA_WIDTH-1:0] bn_a,
    input  logic [CHANNEL_NUM-1:0][PARA_WIDTH-1:0] bn_b,
    input  logic [FM_DEPTH-1:0][DATA_WIDTH-1:0]    res,
    input  logic [CHANNEL_NUM-1:0][IN_WIDTH-1:0]   data_in,
    output logic [CHANNEL_NUM-1:0][DATA_WIDTH-1:0] data_out,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    input  logic                                   sat_clr,
    output logic [CNT_WIDTH-1:0]                   sat_cnt
);

    logic                   s1_valid_r;
    logic                   res_en_r;
    logic                   out_valid_r;
    logic [CNT_WIDTH-1:0]   sat_cnt_r;
    logic                   s1_load_s;
    logic                   s2_load_s;
    logic [CHANNEL_NUM-1:0] sat_vec_s;

    assign s2_load_s = s1_valid_r && (!out_valid_r || out_ready);
    assign in_ready  = rstn && (!s1_valid_r || s2_load_s);
    assign s1_load_s = in_valid && in_ready;
    assign out_valid = out_valid_r;
    assign sat_cnt   = sat_cnt_r;

    for (genvar i = 0; i < CHANNEL_NUM; i++) begin : g_lane
        bn_res_lane #(
            .IN_WIDTH   (IN_WIDTH),
            .PARA_WIDTH (PARA_WIDTH),
            .DATA_WIDTH (DATA_WIDTH),
            .FRAC_SHIFT (FRAC_SHIFT)
        ) u_lane (
            .clk      (clk),
            .rstn     (rstn),
            .s1_load  (s1_load_s),
            .s2_load  (s2_load_s),
            .bn_a     (bn_a[i]),
            .bn_b     (bn_b[i]),
            .data_in  (data_in[i]),
            .res      (res[i % FM_DEPTH]),
            .res_en   (res_en_r),
            .data_out (data_out[i]),
            .sat      (sat_vec_s[i])
        );
    end

    // Valid bits, residual-enable pipe and the saturating beat counter.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            s1_valid_r  <= 1'b0;
            res_en_r    <= 1'b0;
            out_valid_r <= 1'b0;
            sat_cnt_r   <= '0;
        end else begin
            if (s1_load_s) begin
                s1_valid_r <= 1'b1;
                res_en_r   <= res_en;
            end else if (s2_load_s) begin
                s1_valid_r <= 1'b0;
            end
            if (s2_load_s) begin
                out_valid_r <= 1'b1;
            end else if (out_ready) begin
                out_valid_r <= 1'b0;
            end
            if (sat_clr) begin
                sat_cnt_r <= '0;
            end else if (s2_load_s && (|sat_vec_s) && (sat_cnt_r != {CNT_WIDTH{1'b1}})) begin
                sat_cnt_r <= sat_cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_bn_res_pipe.sv
// Directed and randomized checks of bn_res_pipe against an integer reference model.
module tb_bn_res_pipe;

    localparam int CH = 128;
    localparam int FM = 64;
    localparam int DW = 16;
    localparam int PA = 16;
    localparam int IW = 8;

    typedef logic [CH-1:0][DW-1:0] vec_t;
    typedef struct {
        vec_t d0;
        vec_t d2;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rstn, in_valid, res_en, out_ready, sat_clr;
    logic [CH-1:0][PA-1:0]  bn_a, bn_b;
    logic [FM-1:0][DW-1:0]  res;
    logic [CH-1:0][IW-1:0]  data_in;
    vec_t                   data_out0, data_out2;
    logic                   in_ready0, in_ready2, out_valid0, out_valid2;
    logic [15:0]            sat_cnt0, sat_cnt2;

    int    checks = 0;
    int    errors = 0;
    int    sat_m0 = 0;
    int    sat_m2 = 0;
    beat_t q[$];
    vec_t  hold_v;

    bn_res_pipe #(.FRAC_SHIFT(0)) dut0 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready0), .res_en(res_en),
        .bn_a(bn_a), .bn_b(bn_b), .res(res), .data_in(data_in), .data_out(data_out0),
        .out_valid(out_valid0), .out_ready(out_ready), .sat_clr(sat_clr), .sat_cnt(sat_cnt0)
    );

    bn_res_pipe #(.FRAC_SHIFT(2)) dut2 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready2), .res_en(res_en),
        .bn_a(bn_a), .bn_b(bn_b), .res(res), .data_in(data_in), .data_out(data_out2),
        .out_valid(out_valid2), .out_ready(out_ready), .sat_clr(sat_clr), .sat_cnt(sat_cnt2)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_vec(input string tag, input vec_t got, input vec_t exp);
        int idx;
        idx = 0;
        checks++;
        assert (got === exp) else begin
            errors++;
            for (int c = CH - 1; c >= 0; c--) begin
                if (got[c] !== exp[c]) idx = c;
            end
            $error("FAIL %s: ch%0d got %0h expected %0h", tag, idx, got[idx], exp[idx]);
        end
    endtask

    function automatic longint floor_div(input longint n, input longint d);
        longint qt;
        qt = n / d;
        if ((n % d) != 0 && n < 0) qt = qt - 1;
        return qt;
    endfunction

    // Reference: exact integer sum, round half up by floor division, clamp to 16 bits.
    function automatic void model(input int sh, output vec_t v, output bit sat);
        longint s;
        sat = 1'b0;
        for (int c = 0; c < CH; c++) begin
            s = longint'($signed(bn_a[c])) * longint'($signed(data_in[c]))
              + longint'($signed(bn_b[c]))
              + (res_en ? longint'($signed(res[c % FM])) : 64'sd0);
            if (sh > 0) s = floor_div(s + (64'sd1 << (sh - 1)), 64'sd1 << sh);
            if (s > 32767) begin
                s = 32767;
                sat = 1'b1;
            end else if (s < -32768) begin
                s = -32768;
                sat = 1'b1;
            end
            v[c] = s[15:0];
        end
    endfunction

    // One clock: score the outgoing beat, record the accepted one, advance.
    task automatic step();
        beat_t e;
        bit    s0, s2;
        #1;
        if (!rstn) begin
            q.delete();
        end else begin
            if (out_valid0 && out_ready) begin
                if (q.size() == 0) begin
                    chk("beat_expected", 32'(q.size()), 32'd1);
                end else begin
                    chk_vec("data_out0", data_out0, q[0].d0);
                    chk_vec("data_out2", data_out2, q[0].d2);
                    void'(q.pop_front());
                end
            end
            if (in_valid && in_ready0) begin
                model(0, e.d0, s0);
                model(2, e.d2, s2);
                sat_m0 += int'(s0);
                sat_m2 += int'(s2);
                q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_all(input logic [15:0] a, input logic [7:0] d, input logic [15:0] b,
                           input logic [15:0] r);
        for (int c = 0; c < CH; c++) begin
            bn_a[c]    = a;
            data_in[c] = d;
            bn_b[c]    = b;
        end
        for (int k = 0; k < FM; k++) res[k] = r;
    endtask

    task automatic rand_inputs();
        for (int c = 0; c < CH; c++) begin
            if ($urandom_range(1, 0) == 0) begin
                bn_a[c]    = 16'($urandom_range(64, 0)) - 16'd32;
                data_in[c] = 8'($urandom_range(32, 0)) - 8'd16;
                bn_b[c]    = 16'($urandom_range(512, 0)) - 16'd256;
            end else begin
                bn_a[c]    = 16'($urandom);
                data_in[c] = 8'($urandom);
                bn_b[c]    = 16'($urandom);
            end
        end
        for (int k = 0; k < FM; k++) res[k] = 16'($urandom);
        res_en = 1'($urandom);
    endtask

    task automatic send_one();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        chk("out_valid_latency", 32'(out_valid0), 32'd1);
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int i = 0; i < 20 && (q.size() > 0 || out_valid0); i++) step();
        chk({tag, "_left"}, 32'(q.size()), 32'd0);
        chk({tag, "_idle"}, 32'(out_valid0), 32'd0);
        chk({tag, "_sat0"}, 32'(sat_cnt0), 32'(sat_m0));
        chk({tag, "_sat2"}, 32'(sat_cnt2), 32'(sat_m2));
    endtask

    initial begin
        rstn = 1'b0; in_valid = 1'b0; res_en = 1'b0; out_ready = 1'b0; sat_clr = 1'b0;
        set_all(16'd0, 8'd0, 16'd0, 16'd0);
        step();
        step();
        chk("rst_out_valid", 32'(out_valid0), 32'd0);
        chk("rst_in_ready", 32'(in_ready0), 32'd0);
        chk("rst_sat_cnt", 32'(sat_cnt0), 32'd0);
        chk_vec("rst_data_out", data_out0, '0);
        rstn = 1'b1;
        step();

        // Basic beat: 2*3+1+4 = 11, one cycle after accept still empty.
        set_all(16'd2, 8'd3, 16'd1, 16'd4);
        res_en = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("lat_early", 32'(out_valid0), 32'd0);
        step();
        chk("lat_out_valid", 32'(out_valid0), 32'd1);
        chk("basic_ch0", 32'(data_out0[0]), 32'd11);
        chk("basic_ch127", 32'(data_out0[127]), 32'd11);
        drain("basic");

        // Positive and negative saturation.
        set_all(16'd32767, 8'd127, 16'd0, 16'd32767);
        send_one();
        chk("sat_pos", 32'(data_out0[5]), 32'h7fff);
        drain("satpos");
        set_all(16'h8000, 8'd127, 16'd0, 16'h8000);
        send_one();
        chk("sat_neg", 32'(data_out0[5]), 32'h8000);
        drain("satneg");

        // Rounding on the shifted instance; residual disabled.
        set_all(16'd0, 8'd0, 16'd0, 16'd100);
        res_en = 1'b0;
        bn_a[0] = 16'd1; data_in[0] = 8'd5;
        bn_a[1] = 16'd1; data_in[1] = 8'd6;
        bn_a[2] = 16'd1; data_in[2] = 8'hfa;
        send_one();
        chk("rnd_5", 32'(data_out2[0]), 32'd1);
        chk("rnd_6", 32'(data_out2[1]), 32'd2);
        chk("rnd_m6", 32'(data_out2[2]), 32'hffff);
        chk("res_off_ch0", 32'(data_out0[0]), 32'd5);
        chk("res_off_ch3", 32'(data_out0[3]), 32'd0);
        drain("round");

        // Residual wraps every 64 channels.
        set_all(16'd0, 8'd0, 16'd0, 16'd0);
        res[3] = 16'd10; res_en = 1'b1;
        send_one();
        chk("wrap_ch3", 32'(data_out0[3]), 32'd10);
        chk("wrap_ch67", 32'(data_out0[67]), 32'd10);
        chk("wrap_ch4", 32'(data_out0[4]), 32'd0);
        chk("wrap_sh_ch67", 32'(data_out2[67]), 32'd3);
        drain("wrap");

        // Back-pressure: two beats fill the pipe, output holds steady.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rand_inputs();
            in_valid = 1'b1;
            step();
            if (i == 1) begin
                hold_v = data_out0;
                chk("bp_full", 32'(in_ready0), 32'd0);
            end
            if (i > 1) begin
                chk("bp_ready", 32'(in_ready0), 32'd0);
                chk_vec("bp_hold", data_out0, hold_v);
            end
        end
        chk("bp_queued", 32'(q.size()), 32'd2);
        drain("bp");

        // Reset with two beats in flight.
        set_all(16'd32767, 8'd127, 16'd0, 16'd32767);
        res_en = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        step();
        step();
        in_valid = 1'b0;
        rstn = 1'b0;
        step();
        chk("mid_rst_out_valid", 32'(out_valid0), 32'd0);
        chk("mid_rst_sat_cnt", 32'(sat_cnt0), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready0), 32'd0);
        rstn = 1'b1;
        sat_m0 = 0;
        sat_m2 = 0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready0), 32'd1);
        drain("postrst");

        // sat_clr beats a simultaneous saturating beat.
        send_one();
        drain("satone");
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        sat_clr = 1'b1;
        step();
        sat_clr = 1'b0;
        chk("clr_wins", 32'(sat_cnt0), 32'd0);
        sat_m0 = 0;
        sat_m2 = 0;
        drain("clr");

        // Random streaming with random back-pressure.
        for (int i = 0; i < 80; i++) begin
            rand_inputs();
            in_valid  = ($urandom_range(3, 0) != 0);
            out_ready = ($urandom_range(2, 0) != 0);
            step();
        end
        drain("rand");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
